// File: rtl/ibex_rf_readback_if.sv
// rtl/ibex_rf_readback_if.sv - register-file read port and output beat stream bundle
interface ibex_rf_readback_if #(
   parameter int DataWidth = 32
);
   logic                 rf_req_o;
   logic                 rf_gnt_i;
   logic [4:0]           raddr_o;
   logic [DataWidth-1:0] rdata_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [4:0]           out_addr_o;
   logic [DataWidth-1:0] out_data_o;

   modport master (
      output rf_req_o, raddr_o, out_valid_o, out_addr_o, out_data_o,
      input  rf_gnt_i, rdata_i, out_ready_i
   );

   modport slave (
      input  rf_req_o, raddr_o, out_valid_o, out_addr_o, out_data_o,
      output rf_gnt_i, rdata_i, out_ready_i
   );
endinterface

// File: rtl/ibex_rf_readback.sv
// rtl/ibex_rf_readback.sv - sequential register-file dumper streaming {addr,data} beats
module ibex_rf_readback #(
   parameter bit RV32E     = 1'b0,
   parameter int DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [4:0]           first_addr_i,
   input  logic [4:0]           last_addr_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [DataWidth-1:0] signature_o,
   ibex_rf_readback_if.master   bus
);
   localparam logic [4:0] ADDR_MASK = RV32E ? 5'h0F : 5'h1F;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [4:0]           r_cnt;
   logic [4:0]           r_last;
   logic                 r_out_valid;
   logic [4:0]           r_out_addr;
   logic [DataWidth-1:0] r_out_data;
   logic [DataWidth-1:0] r_sig;

   logic                 w_space;
   logic                 w_capture;
   logic                 w_hs;
   logic                 w_abort;
   logic                 w_start;

   assign w_space   = !r_out_valid || bus.out_ready_i;
   assign w_hs      = r_out_valid && bus.out_ready_i;
   assign w_abort   = abort_i && ((r_state == S_READ) || (r_state == S_DRAIN));
   assign w_start   = (r_state == S_IDLE) && start_i;
   // An aborting cycle never captures, so the buffer empties on the way to IDLE.
   assign w_capture = (r_state == S_READ) && !abort_i && bus.rf_gnt_i && w_space;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_i) w_next = S_READ;
         end
         S_READ: begin
            if (abort_i)                             w_next = S_IDLE;
            else if (w_capture && (r_cnt == r_last)) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort_i)   w_next = S_IDLE;
            else if (w_hs) w_next = S_DONE;
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_last      <= '0;
         r_out_valid <= 1'b0;
         r_out_addr  <= '0;
         r_out_data  <= '0;
         r_sig       <= '0;
      end else begin
         r_state <= w_next;

         if (w_start) begin
            r_cnt  <= first_addr_i & ADDR_MASK;
            r_last <= last_addr_i & ADDR_MASK;
         end else if (w_capture) begin
            r_cnt  <= (r_cnt + 5'd1) & ADDR_MASK;
         end

         if (w_capture) begin
            r_out_addr <= r_cnt;
            r_out_data <= bus.rdata_i;
         end

         if (w_abort)        r_out_valid <= 1'b0;
         else if (w_capture) r_out_valid <= 1'b1;
         else if (w_hs)      r_out_valid <= 1'b0;

         // A handshake in the abort cycle is still a delivered beat.
         if (w_start)   r_sig <= '0;
         else if (w_hs) r_sig <= r_sig ^ r_out_data;
      end
   end

   assign busy_o          = (r_state != S_IDLE);
   assign done_o          = (r_state == S_DONE);
   assign signature_o     = r_sig;
   assign bus.rf_req_o    = (r_state == S_READ);
   assign bus.raddr_o     = r_cnt;
   assign bus.out_valid_o = r_out_valid;
   assign bus.out_addr_o  = r_out_addr;
   assign bus.out_data_o  = r_out_data;
endmodule

// File: tb/tb_ibex_rf_readback.sv
// tb/tb_ibex_rf_readback.sv - scoreboard bench for ibex_rf_readback (RV32I and RV32E instances)
module tb_ibex_rf_readback;
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start [2];
   logic        abort [2];
   logic [4:0]  first [2];
   logic [4:0]  last  [2];
   logic        gnt;
   logic [1:0]  rdy;
   logic [31:0] mem   [32];

   logic [1:0]  busy_w, done_w, vld_w, req_w;
   logic [4:0]  raddr_w [2];
   logic [4:0]  oaddr_w [2];
   logic [31:0] odata_w [2];
   logic [31:0] sig_w   [2];

   beat_t       q [2][$];
   logic [31:0] exp_sig [2];
   int          done_cnt [2];
   int          hs_cnt [2];
   int          vectors = 0;
   int          miscompares = 0;
   int          gprob = 100;
   int          rprob = 100;
   bit          gmode = 1'b0;
   int          pcnt = 0;

   always #5 clk = ~clk;

   ibex_rf_readback_if #(.DataWidth(32)) bus0 ();
   ibex_rf_readback_if #(.DataWidth(32)) bus1 ();

   assign bus0.rf_gnt_i    = gnt;
   assign bus1.rf_gnt_i    = gnt;
   assign bus0.out_ready_i = rdy[0];
   assign bus1.out_ready_i = rdy[1];
   assign bus0.rdata_i     = (bus0.raddr_o == 5'd0) ? 32'h0 : mem[bus0.raddr_o];
   assign bus1.rdata_i     = (bus1.raddr_o == 5'd0) ? 32'h0 : mem[bus1.raddr_o];

   assign req_w[0] = bus0.rf_req_o;    assign req_w[1] = bus1.rf_req_o;
   assign vld_w[0] = bus0.out_valid_o; assign vld_w[1] = bus1.out_valid_o;
   assign raddr_w[0] = bus0.raddr_o;   assign raddr_w[1] = bus1.raddr_o;
   assign oaddr_w[0] = bus0.out_addr_o; assign oaddr_w[1] = bus1.out_addr_o;
   assign odata_w[0] = bus0.out_data_o; assign odata_w[1] = bus1.out_data_o;

   ibex_rf_readback #(.RV32E(1'b0), .DataWidth(32)) dut0 (
      .clk_i(clk), .rst_i(rst), .start_i(start[0]), .abort_i(abort[0]),
      .first_addr_i(first[0]), .last_addr_i(last[0]),
      .busy_o(busy_w[0]), .done_o(done_w[0]), .signature_o(sig_w[0]), .bus(bus0.master)
   );

   ibex_rf_readback #(.RV32E(1'b1), .DataWidth(32)) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start[1]), .abort_i(abort[1]),
      .first_addr_i(first[1]), .last_addr_i(last[1]),
      .busy_o(busy_w[1]), .done_o(done_w[1]), .signature_o(sig_w[1]), .bus(bus1.master)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Grant/ready driver: random by probability, or a 1,0,0 grant pattern.
   initial begin
      gnt = 1'b0;
      rdy = 2'b00;
      forever begin
         @(posedge clk);
         #1;
         if (gmode) gnt = (pcnt % 3 == 0);
         else       gnt = ($urandom_range(99) < gprob);
         pcnt++;
         for (int i = 0; i < 2; i++) rdy[i] = ($urandom_range(99) < rprob);
      end
   end

   // Monitor: every presented beat must equal the head of the expected queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (req_w[1]) chk("rv32e_raddr_msb", {63'd0, raddr_w[1][4]}, 64'd0);
         for (int i = 0; i < 2; i++) begin
            if (done_w[i]) done_cnt[i]++;
            if (vld_w[i]) begin
               if (q[i].size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_beat[%0d]: got addr %0h data %0h expected none", i, oaddr_w[i], odata_w[i]);
               end else begin
                  chk($sformatf("beat_addr[%0d]", i), {59'd0, oaddr_w[i]}, {59'd0, q[i][0].a});
                  chk($sformatf("beat_data[%0d]", i), {32'd0, odata_w[i]}, {32'd0, q[i][0].d});
                  if (rdy[i]) begin
                     void'(q[i].pop_front());
                     hs_cnt[i]++;
                  end
               end
            end
         end
      end
   end

   task automatic fill_mem(input int kind);
      for (int k = 0; k < 32; k++) begin
         case (kind)
            0:       mem[k] = 32'h100 + k;
            1:       mem[k] = k;
            default: mem[k] = $urandom;
         endcase
      end
   endtask

   task automatic start_dump(input int i, input logic [4:0] f, input logic [4:0] l);
      int          nw;
      logic [4:0]  a, le;
      beat_t       b;
      nw = (i == 1) ? 16 : 32;
      a  = f % nw;
      le = l % nw;
      exp_sig[i] = 32'h0;
      q[i].delete();
      hs_cnt[i] = 0;
      for (int n = 0; n < 32; n++) begin
         b.a = a;
         b.d = (a == 5'd0) ? 32'h0 : mem[a];
         q[i].push_back(b);
         exp_sig[i] ^= b.d;
         if (a == le) break;
         a = (a + 1) % nw;
      end
      @(posedge clk); #2;
      first[i] = f;
      last[i]  = l;
      start[i] = 1'b1;
      @(posedge clk); #2;
      start[i] = 1'b0;
   endtask

   task automatic finish_dump(input int i, input string tag);
      int d0, n;
      int nbeats;
      nbeats = q[i].size() + hs_cnt[i];
      d0 = done_cnt[i];
      n  = 0;
      while (done_cnt[i] == d0 && n < 3000) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 3000) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: no done after %0d cycles, required a done pulse", tag, n);
         abort[i] = 1'b1;
         @(posedge clk); #2;
         abort[i] = 1'b0;
         q[i].delete();
      end else begin
         chk({tag, "_busy"}, {63'd0, busy_w[i]}, 64'd0);
         chk({tag, "_sig"}, {32'd0, sig_w[i]}, {32'd0, exp_sig[i]});
         chk({tag, "_left"}, q[i].size(), 0);
         chk({tag, "_beats"}, hs_cnt[i], nbeats);
         @(posedge clk); #2;
         @(posedge clk); #2;
         chk({tag, "_done_once"}, done_cnt[i], d0 + 1);
         chk({tag, "_sig_hold"}, {32'd0, sig_w[i]}, {32'd0, exp_sig[i]});
      end
   endtask

   initial begin
      int n;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; abort[i] = 1'b0; first[i] = '0; last[i] = '0;
         done_cnt[i] = 0; hs_cnt[i] = 0; exp_sig[i] = '0;
      end
      fill_mem(0);
      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", {62'd0, busy_w}, 64'd0);
      chk("rst_done", {62'd0, done_w}, 64'd0);
      chk("rst_valid", {62'd0, vld_w}, 64'd0);
      chk("rst_req", {62'd0, req_w}, 64'd0);
      chk("rst_sig", {32'd0, sig_w[0]}, 64'd0);
      rst = 1'b0;

      // Basic run 1..4, continuous grant/ready, 1 beat/cycle.
      start_dump(0, 5'd1, 5'd4);
      chk("lat_pre_valid", {63'd0, vld_w[0]}, 64'd0);
      @(posedge clk); #2;
      chk("first_beat_valid", {63'd0, vld_w[0]}, 64'd1);
      for (int k = 1; k < 4; k++) begin
         @(posedge clk); #2;
         chk("throughput_addr", {59'd0, oaddr_w[0]}, 1 + k);
      end
      finish_dump(0, "basic");
      chk("basic_sig_const", {32'd0, sig_w[0]}, 64'h4);

      // Wrap 30 -> 1.
      fill_mem(1);
      start_dump(0, 5'd30, 5'd1);
      finish_dump(0, "wrap");
      chk("wrap_sig_const", {32'd0, sig_w[0]}, 64'h0);

      // Backpressure; a start while busy must be ignored.
      fill_mem(0);
      rprob = 0;
      start_dump(0, 5'd1, 5'd4);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #2;
         start[0] = (k == 0);
         first[0] = 5'd9;
         chk("bp_valid", {63'd0, vld_w[0]}, 64'd1);
         chk("bp_addr", {59'd0, oaddr_w[0]}, 64'd1);
         chk("bp_data", {32'd0, odata_w[0]}, 64'h101);
         chk("bp_raddr", {59'd0, raddr_w[0]}, 64'd2);
         chk("bp_req", {63'd0, req_w[0]}, 64'd1);
      end
      start[0] = 1'b0;
      rprob = 100;
      finish_dump(0, "backpressure");

      // Grant pattern 1,0,0.
      gmode = 1'b1;
      start_dump(0, 5'd1, 5'd4);
      finish_dump(0, "gnt_stall");
      gmode = 1'b0;

      // Abort after the second handshake.
      start_dump(0, 5'd1, 5'd10);
      n = 0;
      while (hs_cnt[0] < 2 && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      chk("abort_reached_2", {63'd0, (hs_cnt[0] >= 2)}, 64'd1);
      abort[0] = 1'b1;
      rdy[0]   = 1'b0;
      n = done_cnt[0];
      @(posedge clk); #2;
      abort[0] = 1'b0;
      chk("abort_busy", {63'd0, busy_w[0]}, 64'd0);
      chk("abort_valid", {63'd0, vld_w[0]}, 64'd0);
      chk("abort_req", {63'd0, req_w[0]}, 64'd0);
      chk("abort_sig", {32'd0, sig_w[0]}, 64'h3);
      q[0].delete();
      repeat (3) @(posedge clk);
      #2;
      chk("abort_no_done", done_cnt[0], n);

      // Asynchronous reset mid-READ.
      start_dump(0, 5'd1, 5'd20);
      repeat (3) @(posedge clk);
      #2;
      n = done_cnt[0];
      rst = 1'b1;
      #1;
      chk("mrst_busy", {63'd0, busy_w[0]}, 64'd0);
      chk("mrst_req", {63'd0, req_w[0]}, 64'd0);
      chk("mrst_raddr", {59'd0, raddr_w[0]}, 64'd0);
      chk("mrst_valid", {63'd0, vld_w[0]}, 64'd0);
      chk("mrst_oaddr", {59'd0, oaddr_w[0]}, 64'd0);
      chk("mrst_odata", {32'd0, odata_w[0]}, 64'd0);
      chk("mrst_sig", {32'd0, sig_w[0]}, 64'd0);
      q[0].delete();
      @(posedge clk); #2;
      rst = 1'b0;
      chk("mrst_no_done", done_cnt[0], n);

      // RV32E masking: 0x13..0x14 -> 3..4.
      fill_mem(2);
      start_dump(1, 5'h13, 5'h14);
      finish_dump(1, "rv32e");
      chk("rv32e_count", hs_cnt[1], 2);

      // Randomized dumps on both instances.
      for (int t = 0; t < 24; t++) begin
         int i;
         i = $urandom_range(1);
         fill_mem(2);
         gprob = $urandom_range(100, 40);
         rprob = $urandom_range(100, 40);
         start_dump(i, 5'($urandom_range(31)), 5'($urandom_range(31)));
         finish_dump(i, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end
endmodule
